// File: rtl/joint_step_driver.sv
// Stepper driver for one SCARA joint: scales a Q3.10 angle to a step target and steps until reached.
// Optional target clamp to +/-SOFT_LIMIT is enabled by defining JOINT_STEP_SOFT_LIMIT_EN.
module joint_step_driver #(
   parameter int unsigned STEPS_PER_RAD = 1019,
   parameter int          POS_W         = 16,
   parameter int unsigned STEP_PERIOD   = 2500,
   parameter int unsigned PULSE_WIDTH   = 250,
   parameter int unsigned DIR_SETUP     = 50,
   parameter int          SOFT_LIMIT    = 3000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [12:0]      angle,
   input  logic                    angle_valid,
   input  logic                    enable,
   output logic                    step,
   output logic                    dir,
   output logic signed [POS_W-1:0] position,
   output logic                    busy,
   output logic                    done
);

   localparam int unsigned CNT_MAX = (STEP_PERIOD > DIR_SETUP) ? STEP_PERIOD : DIR_SETUP;
   localparam int          CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DIR_SETUP - 1);
   localparam logic [CNT_W-1:0] HI_LAST    = CNT_W'(PULSE_WIDTH - 1);
   localparam logic [CNT_W-1:0] LO_LAST    = CNT_W'(STEP_PERIOD - PULSE_WIDTH - 1);
   localparam logic signed [23:0] LIM      = 24'(SOFT_LIMIT);
`ifdef JOINT_STEP_SOFT_LIMIT_EN
   localparam bit CLAMP_EN = 1'b1;
`else
   localparam bit CLAMP_EN = 1'b0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_SCALE, S_SETUP, S_STEP_HI, S_STEP_LO, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic signed [12:0]      angle_q, angle_d;
   logic                    sc_pend_q, sc_pend_d;
   logic                    pend_q, pend_d;
   logic signed [POS_W-1:0] pend_tgt_q, pend_tgt_d;
   logic signed [POS_W-1:0] target_q, target_d;
   logic signed [POS_W-1:0] position_q, position_d;
   logic                    dir_q, dir_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic signed [POS_W-1:0] scaled, new_tgt;
   logic                    has_new;

   // floor(angle * STEPS_PER_RAD / 1024), optionally clamped before narrowing to POS_W
   function automatic logic signed [POS_W-1:0] scale_angle(input logic signed [12:0] a);
      logic signed [23:0] prod;
      logic signed [23:0] shf;
      prod = 24'(a) * $signed(24'(STEPS_PER_RAD));
      shf  = prod >>> 10;
      if (CLAMP_EN && (shf > LIM)) shf = LIM;
      if (CLAMP_EN && (shf < -LIM)) shf = -LIM;
      return POS_W'(shf);
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         angle_q    <= '0;
         sc_pend_q  <= 1'b0;
         pend_q     <= 1'b0;
         pend_tgt_q <= '0;
         target_q   <= '0;
         position_q <= '0;
         dir_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         angle_q    <= angle_d;
         sc_pend_q  <= sc_pend_d;
         pend_q     <= pend_d;
         pend_tgt_q <= pend_tgt_d;
         target_q   <= target_d;
         position_q <= position_d;
         dir_q      <= dir_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      angle_d    = angle_valid ? angle : angle_q;
      sc_pend_d  = sc_pend_q;
      pend_d     = pend_q;
      pend_tgt_d = pend_tgt_q;
      target_d   = target_q;
      position_d = position_q;
      dir_d      = dir_q;
      cnt_d      = cnt_q;
      scaled     = scale_angle(angle_q);
      // a strobe scaled this cycle supersedes an older stored one
      new_tgt    = sc_pend_q ? scaled : pend_tgt_q;
      has_new    = sc_pend_q | pend_q;
      case (state_q)
         S_IDLE: begin
            if (angle_valid) state_d = S_SCALE;
         end
         S_SCALE: begin
            target_d  = scaled;
            sc_pend_d = angle_valid;
            pend_d    = 1'b0;
            cnt_d     = '0;
            if (scaled == position_q) state_d = S_DONE;
            else begin
               state_d = S_SETUP;
               dir_d   = (scaled > position_q);
            end
         end
         S_SETUP: begin
            sc_pend_d = angle_valid;
            if (sc_pend_q) begin
               target_d = scaled;
               cnt_d    = '0;
               if (scaled == position_q) state_d = S_DONE;
               else dir_d = (scaled > position_q);
            end else if (enable) begin
               if (cnt_q == SETUP_LAST) begin
                  cnt_d   = '0;
                  state_d = S_STEP_HI;
               end else cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_STEP_HI: begin
            sc_pend_d = angle_valid;
            if (sc_pend_q) begin
               pend_d     = 1'b1;
               pend_tgt_d = scaled;
            end
            if (cnt_q == HI_LAST) begin
               cnt_d      = '0;
               position_d = dir_q ? position_q + POS_W'(1) : position_q - POS_W'(1);
               state_d    = S_STEP_LO;
            end else cnt_d = cnt_q + CNT_W'(1);
         end
         S_STEP_LO: begin
            sc_pend_d = angle_valid;
            if (sc_pend_q) begin
               pend_d     = 1'b1;
               pend_tgt_d = scaled;
            end
            if (cnt_q != LO_LAST) cnt_d = cnt_q + CNT_W'(1);
            else if (has_new) begin
               pend_d   = 1'b0;
               target_d = new_tgt;
               if (new_tgt == position_q) begin
                  cnt_d   = '0;
                  state_d = S_DONE;
               end else if ((new_tgt > position_q) != dir_q) begin
                  dir_d   = ~dir_q;
                  cnt_d   = '0;
                  state_d = S_SETUP;
               end else if (enable) begin
                  cnt_d   = '0;
                  state_d = S_STEP_HI;
               end
            end else if (position_q == target_q) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else if (enable) begin
               cnt_d   = '0;
               state_d = S_STEP_HI;
            end
         end
         S_DONE: begin
            sc_pend_d = 1'b0;
            state_d   = (angle_valid || sc_pend_q) ? S_SCALE : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      step     = (state_q == S_STEP_HI);
      busy     = (state_q == S_SCALE) || (state_q == S_SETUP) ||
                 (state_q == S_STEP_HI) || (state_q == S_STEP_LO);
      done     = (state_q == S_DONE);
      dir      = dir_q;
      position = position_q;
   end

endmodule

// File: tb/tb_joint_step_driver.sv
// Directed bench for joint_step_driver using the small-timing configuration (period 4, pulse 2, setup 3).
module tb_joint_step_driver;
   localparam int POS_W    = 16;
   localparam int SOFT_LIM = 1000;

   logic                    clk = 1'b0;
   logic                    reset;
   logic signed [12:0]      angle;
   logic                    angle_valid;
   logic                    enable;
   logic                    step;
   logic                    dir;
   logic signed [POS_W-1:0] position;
   logic                    busy;
   logic                    done;

   int n_chk  = 0;
   int n_fail = 0;

   joint_step_driver #(
      .STEPS_PER_RAD(1019), .POS_W(POS_W), .STEP_PERIOD(4), .PULSE_WIDTH(2),
      .DIR_SETUP(3), .SOFT_LIMIT(SOFT_LIM)
   ) dut (
      .clk(clk), .reset(reset), .angle(angle), .angle_valid(angle_valid), .enable(enable),
      .step(step), .dir(dir), .position(position), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [12:0] ang;
      int          exp_tgt;
   } vec_t;
   vec_t vecs[8];

   function automatic int lim(input int v);
`ifdef JOINT_STEP_SOFT_LIMIT_EN
      if (v > SOFT_LIM) return SOFT_LIM;
      if (v < -SOFT_LIM) return -SOFT_LIM;
`endif
      return v;
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic strobe(input logic [12:0] a);
      angle       = a;
      angle_valid = 1'b1;
      @(negedge clk);
      angle_valid = 1'b0;
   endtask

   task automatic wait_pos(input string nm, input int p, input int budget);
      int k;
      k = 0;
      while (int'(position) != p && k < budget) begin
         @(negedge clk);
         k++;
      end
      check({nm, "_reach_pos"}, int'(position), p);
   endtask

   task automatic run_move(input string nm, input logic [12:0] a, input int exp_pos,
                           input int exp_steps, input logic exp_dir);
      int rises, first, last, bad_gap, dones, budget, extra;
      logic prev, dir_bad, fin;
      rises = 0; first = -1; last = 0; bad_gap = 0; dones = 0; extra = 0;
      dir_bad = 1'b0; fin = 1'b0;
      budget = exp_steps * 4 + 40;
      strobe(a);
      check({nm, "_busy_start"}, busy, 1);
      prev = step;
      for (int k = 1; k <= budget && !fin; k++) begin
         if (step && !prev) begin
            rises++;
            if (first < 0) first = k;
            else if (k - last != 4) bad_gap++;
            last = k;
            if (dir !== exp_dir) dir_bad = 1'b1;
         end
         if (k == 2 && exp_steps > 0 && dir !== exp_dir) dir_bad = 1'b1;
         if (done) begin
            dones++;
            fin = 1'b1;
            check({nm, "_busy_at_done"}, busy, 0);
         end
         prev = step;
         @(negedge clk);
      end
      for (int j = 0; j < 5; j++) begin
         if (done) dones++;
         if (step) extra++;
         @(negedge clk);
      end
      check({nm, "_done_seen"}, fin, 1);
      check({nm, "_done_count"}, dones, 1);
      check({nm, "_steps"}, rises + extra, exp_steps);
      check({nm, "_position"}, int'(position), exp_pos);
      check({nm, "_busy_end"}, busy, 0);
      if (exp_steps > 0) begin
         check({nm, "_first_rise"}, first, 5);
         check({nm, "_gaps"}, bad_gap, 0);
         check({nm, "_dir"}, dir_bad, 0);
      end
   endtask

   initial begin
      int prev_pos, tgt, rises, first, dones, maxpos, bad;
      logic prev, dir_k2, fin;

      vecs[0] = '{13'h0400,  1019};
      vecs[1] = '{13'h1C00, -1019};
      vecs[2] = '{13'h0000,     0};
      vecs[3] = '{13'h0000,     0};
      vecs[4] = '{13'h0010,    15};
      vecs[5] = '{13'h1FF0,   -16};
      vecs[6] = '{13'h0001,     0};
      vecs[7] = '{13'h1FFF,    -1};

      reset = 1'b0; angle = '0; angle_valid = 1'b0; enable = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_step", step, 0);
      check("rst_dir", dir, 0);
      check("rst_position", int'(position), 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      reset = 1'b1;
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (step || busy || done || position != 0) bad++;
      end
      check("idle_quiet", bad, 0);

      prev_pos = 0;
      for (int i = 0; i < 8; i++) begin
         tgt = lim(vecs[i].exp_tgt);
         run_move($sformatf("vec%0d", i), vecs[i].ang, tgt,
                  (tgt > prev_pos) ? tgt - prev_pos : prev_pos - tgt, tgt > prev_pos);
         prev_pos = tgt;
      end

      // reset in the middle of a step pulse
      strobe(13'h0010);
      bad = 0;
      while (!step && bad < 50) begin
         @(negedge clk);
         bad++;
      end
      check("midrst_step_before", step, 1);
      reset = 1'b0;
      #1;
      check("midrst_step", step, 0);
      check("midrst_busy", busy, 0);
      check("midrst_position", int'(position), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // retarget while stepping: reverse back to zero
      strobe(13'h0010);
      wait_pos("retgt", 5, 200);
      check("retgt_step_low", step, 0);
      strobe(13'h0000);
      rises = 0; first = -1; dones = 0; maxpos = 5; fin = 1'b0; dir_k2 = 1'b1;
      prev = step;
      for (int k = 1; k <= 200 && !fin; k++) begin
         if (step && !prev) begin
            rises++;
            if (first < 0) first = k;
         end
         if (k == 2) dir_k2 = dir;
         if (int'(position) > maxpos) maxpos = int'(position);
         if (done) begin
            dones++;
            fin = 1'b1;
         end
         prev = step;
         @(negedge clk);
      end
      for (int j = 0; j < 5; j++) begin
         if (done) dones++;
         @(negedge clk);
      end
      check("retgt_dir", dir_k2, 0);
      check("retgt_first_rise", first, 5);
      check("retgt_rev_steps", rises, 5);
      check("retgt_max_pos", maxpos, 5);
      check("retgt_position", int'(position), 0);
      check("retgt_done_count", dones, 1);

      // enable dropped mid-move freezes motion
      strobe(13'h0010);
      wait_pos("hold", 7, 200);
      enable = 1'b0;
      bad = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (step || position != 7 || !busy) bad++;
      end
      check("hold_frozen", bad, 0);
      enable = 1'b1;
      bad = 0;
      while (!done && bad < 200) begin
         @(negedge clk);
         bad++;
      end
      check("hold_done", done, 1);
      check("hold_position", int'(position), 15);

      // pi radians, clamped only when the soft limit is built in
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      tgt = lim(3200);
      run_move("pi", 13'h0C90, tgt, tgt, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
